mapping_group_ctrl: RTL
=======================

MAPPING_GROUP_CTRL -- requirements
Module: mapping_group_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock, rising edge; rst_ni  in  1  reset, asynchronous, active-low.
REQ-002 The block SHALL have these inputs:
- start_i  in  1  begin job (sampled in IDLE only)
- abort_i  in  1  abandon job, return to IDLE
- cfg_mode_i  in  1  0 = single-write, 1 = dual-write
- cfg_passes_i  in  4  accumulate passes per job (0 treated as 1)
- cfg_shift_len_i  in  3  shift phase length minus 1
- cfg_zp_load_i  in  1  load zero point (IDLE only)
- cfg_zp_i  in  32  zero-point value
- data_valid_i  in  1  macro output word valid
- load_req_i  in  1  request result load
REQ-003 The block SHALL have these outputs:
- buf_write_en_1_o  out  1  write buffer 1
- buf_write_en_2_o  out  1  write buffer 2
- buf_read_en_o  out  1  buffer read
- shift_counter_en_o  out  1  shift counter enable
- mode_o  out  1  latched job mode
- accum_buf_write_o  out  1  accumulate write
- zero_point_en_o  out  1  zero-point register enable
- zero_point_o  out  32  zero-point data
- load_en_o  out  1  load strobe
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle done pulse
- pass_cnt_o  out  4  completed passes

Function
REQ-004 The FSM SHALL have states IDLE, WAIT1, WR1, WAIT2, WR2, SHIFT, ACCUM, READY, LOAD, held in a registered state vector.
REQ-005 All strobe outputs SHALL be decoded from the registered state only (Moore), with no combinational path from any input.
REQ-006 Transitions: IDLE->WAIT1 on start_i; WAIT1->WR1 on data_valid_i; WR1->WAIT2 if mode_o=1, else WR1->SHIFT.
REQ-007 Further transitions: WAIT2->WR2 on data_valid_i; WR2->SHIFT; SHIFT->ACCUM after exactly cfg_shift_len_i+1 cycles in SHIFT.
REQ-008 After ACCUM the FSM SHALL go to READY if the incremented pass count equals the effective pass count, else to WAIT1; READY->LOAD on load_req_i; LOAD->IDLE after one cycle.
REQ-009 Strobe decode: buf_write_en_1_o=1 in WR1 only; buf_write_en_2_o=1 in WR2 only; buf_read_en_o and shift_counter_en_o=1 in SHIFT only; accum_buf_write_o=1 in ACCUM only; load_en_o=1 in LOAD only.
REQ-010 busy_o SHALL be 1 in every state except IDLE and READY.
REQ-011 done_o SHALL be 1 only for the first cycle in READY.
REQ-012 mode_o, the effective pass count (max(cfg_passes_i,1)) and the shift length SHALL be captured from the cfg inputs on the start_i cycle and held until IDLE is re-entered; cfg changes mid-job have no effect.
REQ-013 pass_cnt_o SHALL clear to 0 on start acceptance and increment by 1 on the ACCUM cycle, saturating at 15; it holds its value through READY and LOAD.
REQ-014 The shift cycle counter SHALL be 3 bits, clear on SHIFT entry, and produce no wrap-around behaviour beyond 8 cycles.
REQ-015 On cfg_zp_load_i in IDLE, zero_point_o SHALL register cfg_zp_i and zero_point_en_o SHALL pulse for exactly one cycle on the next cycle; cfg_zp_load_i outside IDLE SHALL be ignored.
REQ-016 If cfg_zp_load_i and start_i occur in the same IDLE cycle, both SHALL be accepted.
REQ-017 zero_point_o SHALL hold its value between loads.
REQ-018 abort_i SHALL have priority over every other input and force IDLE on the next edge, so all strobes are 0 the following cycle.
REQ-019 abort_i SHALL leave pass_cnt_o and zero_point_o unchanged and SHALL NOT pulse done_o.
REQ-020 start_i outside IDLE, data_valid_i outside WAIT1/WAIT2, and load_req_i outside READY SHALL be ignored.

Reset
REQ-021 On rst_ni low, asynchronously: state=IDLE; all strobes, mode_o, busy_o, done_o = 0; pass_cnt_o=0; zero_point_o=0.
REQ-022 Reset asserted mid-job SHALL abandon the job, and no strobe SHALL be asserted in the first cycle after release.

Verification
REQ-023 mode=1, passes=2, shift_len=3, data_valid_i each WAIT -> per pass: WR1 1 cycle, WR2 1 cycle, 4 SHIFT cycles, 1 ACCUM; done_o pulse; pass_cnt_o=2; load_req_i -> load_en_o for 1 cycle, then IDLE.
REQ-024 mode=0, passes=0 -> buf_write_en_2_o never asserts; exactly 1 ACCUM; pass_cnt_o=1.
REQ-025 cfg_zp_i=0xDEADBEEF with cfg_zp_load_i and start_i in the same IDLE cycle -> zero_point_en_o 1 cycle later, zero_point_o=0xDEADBEEF, job starts.
REQ-026 abort_i during SHIFT cycle 2 -> IDLE next cycle; no ACCUM; done_o stays 0; a new start_i is accepted.
REQ-027 rst_ni low during WAIT2 -> all outputs 0 immediately; start_i ignored while reset is held.
REQ-028 cfg_passes_i changed 5->1 mid-job after start with 5 -> 5 ACCUM pulses occur before READY.

Source files
------------

// File: rtl/mapping_group_ctrl.sv
`default_nettype none
// ============================================================================
// mapping_group_ctrl : Moore sequencer for macro write/shift/accumulate passes
// Revision 1.0
// ============================================================================
module mapping_group_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        cfg_mode_i,
   input  logic [3:0]  cfg_passes_i,
   input  logic [2:0]  cfg_shift_len_i,
   input  logic        cfg_zp_load_i,
   input  logic [31:0] cfg_zp_i,
   input  logic        data_valid_i,
   input  logic        load_req_i,
   output logic        buf_write_en_1_o,
   output logic        buf_write_en_2_o,
   output logic        buf_read_en_o,
   output logic        shift_counter_en_o,
   output logic        mode_o,
   output logic        accum_buf_write_o,
   output logic        zero_point_en_o,
   output logic [31:0] zero_point_o,
   output logic        load_en_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [3:0]  pass_cnt_o
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      WAIT1 = 4'd1,
      WR1   = 4'd2,
      WAIT2 = 4'd3,
      WR2   = 4'd4,
      SHIFT = 4'd5,
      ACCUM = 4'd6,
      READY = 4'd7,
      LOAD  = 4'd8
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        mode_q;
   logic [3:0]  passes_q;
   logic [2:0]  shift_len_q;
   logic [2:0]  shift_cnt;
   logic [3:0]  pass_cnt;
   logic [3:0]  pass_inc;
   logic [31:0] zp_q;
   logic        zp_en_q;
   logic        done_q;
   logic        start_acc;
   logic        zp_acc;

   assign pass_inc  = (pass_cnt == 4'hF) ? 4'hF : pass_cnt + 4'd1;
   assign start_acc = (state_q == IDLE) && start_i && !abort_i;
   assign zp_acc    = (state_q == IDLE) && cfg_zp_load_i && !abort_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_i) state_d = WAIT1;
            WAIT1:   if (data_valid_i) state_d = WR1;
            WR1:     state_d = mode_q ? WAIT2 : SHIFT;
            WAIT2:   if (data_valid_i) state_d = WR2;
            WR2:     state_d = SHIFT;
            SHIFT:   if (shift_cnt == shift_len_q) state_d = ACCUM;
            ACCUM:   state_d = (pass_inc == passes_q) ? READY : WAIT1;
            READY:   if (load_req_i) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Job configuration is frozen at start so mid-job cfg changes are inert.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q      <= 1'b0;
         passes_q    <= 4'd1;
         shift_len_q <= 3'd0;
         shift_cnt   <= 3'd0;
         pass_cnt    <= 4'd0;
         zp_q        <= 32'd0;
         zp_en_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (start_acc) begin
            mode_q      <= cfg_mode_i;
            passes_q    <= (cfg_passes_i == 4'd0) ? 4'd1 : cfg_passes_i;
            shift_len_q <= cfg_shift_len_i;
            pass_cnt    <= 4'd0;
         end else if (state_q == ACCUM && !abort_i) begin
            pass_cnt <= pass_inc;
         end

         if (state_q != SHIFT) begin
            shift_cnt <= 3'd0;
         end else if (shift_cnt != shift_len_q) begin
            shift_cnt <= shift_cnt + 3'd1;
         end

         if (zp_acc) begin
            zp_q <= cfg_zp_i;
         end
         zp_en_q <= zp_acc;

         // done marks only the entry cycle into READY.
         done_q <= (state_d == READY) && (state_q != READY);
      end
   end

   assign buf_write_en_1_o   = (state_q == WR1);
   assign buf_write_en_2_o   = (state_q == WR2);
   assign buf_read_en_o      = (state_q == SHIFT);
   assign shift_counter_en_o = (state_q == SHIFT);
   assign accum_buf_write_o  = (state_q == ACCUM);
   assign load_en_o          = (state_q == LOAD);
   assign busy_o             = (state_q != IDLE) && (state_q != READY);
   assign done_o             = done_q;
   assign mode_o             = mode_q;
   assign pass_cnt_o         = pass_cnt;
   assign zero_point_o       = zp_q;
   assign zero_point_en_o    = zp_en_q;

endmodule
`default_nettype wire
